// File: rtl/acc_multicycle_core.sv
// Multi-cycle accumulator core (FSM, IR, PC, register file, ALU). Zero-wait latency is 2-4 cycles per instruction.
// A memory request is held stable until mem_ready; each wait cycle adds one cycle.
module acc_multicycle_core #(
    parameter int WORD_LEN  = 16,
    parameter int ADDR_LEN  = 12,
    parameter int REG_COUNT = 8
) (
    input  logic                clk,
    input  logic                rst,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_LEN-1:0] mem_addr,
    output logic [WORD_LEN-1:0] mem_wdata,
    input  logic [WORD_LEN-1:0] mem_rdata,
    input  logic                mem_ready,
    output logic                halted,
    output logic [ADDR_LEN-1:0] dbg_pc,
    output logic [WORD_LEN-1:0] dbg_r0
);
    localparam int W  = WORD_LEN;
    localparam int A  = ADDR_LEN;
    localparam int RA = $clog2(REG_COUNT);
    localparam logic [A-1:0] PC_STEP = 1;

    localparam logic [3:0] OP_LOAD  = 4'd0;
    localparam logic [3:0] OP_STORE = 4'd1;
    localparam logic [3:0] OP_JUMP  = 4'd2;
    localparam logic [3:0] OP_BRZ   = 4'd3;
    localparam logic [3:0] OP_ADD   = 4'd4;
    localparam logic [3:0] OP_SUB   = 4'd5;
    localparam logic [3:0] OP_AND   = 4'd6;
    localparam logic [3:0] OP_OR    = 4'd7;
    localparam logic [3:0] OP_MVTO  = 4'd8;
    localparam logic [3:0] OP_MVFR  = 4'd9;
    localparam logic [3:0] OP_ADDR  = 4'd10;
    localparam logic [3:0] OP_SUBR  = 4'd11;
    localparam logic [3:0] OP_NOT   = 4'd12;
    localparam logic [3:0] OP_ADDI  = 4'd13;
    localparam logic [3:0] OP_HALT  = 4'd14;
    localparam logic [3:0] OP_NOP   = 4'd15;

    typedef enum logic [2:0] {
        S_INIT, S_FETCH, S_DECODE, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_REG_EXEC, S_HALT
    } state_t;

    state_t         state, state_nxt;
    logic [A-1:0]   pc;
    logic [W-1:0]   ir, mdr, b;
    logic [W-1:0]   regs [REG_COUNT];

    logic [3:0]     opcode;
    logic [A-1:0]   addr_f;
    logic [RA-1:0]  ri;
    logic [W-1:0]   r0, imm_sext;

    assign opcode   = ir[W-1:W-4];
    assign addr_f   = ir[A-1:0];
    assign ri       = ir[RA-1:0];
    assign r0       = regs[0];
    assign imm_sext = {{(W-A){ir[A-1]}}, ir[A-1:0]};

    assign halted = (state == S_HALT);
    assign dbg_pc = pc;
    assign dbg_r0 = r0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_INIT;
        else     state <= state_nxt;
    end

    // Memory outputs are pure state decode so an async reset drops mem_req at once.
    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            S_INIT: state_nxt = S_FETCH;
            S_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc;
                if (mem_ready) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_JUMP, OP_BRZ, OP_NOP:             state_nxt = S_FETCH;
                    OP_HALT:                             state_nxt = S_HALT;
                    OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR: state_nxt = S_MEM_RD;
                    OP_STORE:                            state_nxt = S_MEM_WR;
                    default:                             state_nxt = S_REG_EXEC;
                endcase
            end
            S_MEM_RD: begin
                mem_req  = 1'b1;
                mem_addr = addr_f;
                if (mem_ready) state_nxt = S_MEM_WB;
            end
            S_MEM_WB: state_nxt = S_FETCH;
            S_MEM_WR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addr_f;
                mem_wdata = r0;
                if (mem_ready) state_nxt = S_FETCH;
            end
            S_REG_EXEC: state_nxt = S_FETCH;
            S_HALT:     state_nxt = S_HALT;
            default:    state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc  <= '0;
            ir  <= '0;
            mdr <= '0;
            b   <= '0;
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem_ready) begin
                        ir <= mem_rdata;
                        pc <= pc + PC_STEP;
                    end
                end
                S_DECODE: begin
                    b <= regs[ri];
                    if (opcode == OP_JUMP || (opcode == OP_BRZ && r0 == '0)) pc <= addr_f;
                end
                S_MEM_RD: if (mem_ready) mdr <= mem_rdata;
                S_MEM_WB: begin
                    case (opcode)
                        OP_LOAD: regs[0] <= mdr;
                        OP_ADD:  regs[0] <= r0 + mdr;
                        OP_SUB:  regs[0] <= r0 - mdr;
                        OP_AND:  regs[0] <= r0 & mdr;
                        OP_OR:   regs[0] <= r0 | mdr;
                        default: ;
                    endcase
                end
                // B holds reg[Ri] captured in DECODE, so Ri == R0 cases fall out naturally.
                S_REG_EXEC: begin
                    case (opcode)
                        OP_MVTO: regs[ri] <= r0;
                        OP_MVFR: regs[0]  <= b;
                        OP_ADDR: regs[0]  <= r0 + b;
                        OP_SUBR: regs[0]  <= r0 - b;
                        OP_NOT:  regs[ri] <= ~b;
                        OP_ADDI: regs[0]  <= r0 + imm_sext;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_acc_multicycle_core.sv
// Directed-program bench for acc_multicycle_core with a unified memory model and optional wait states.
module tb_acc_multicycle_core;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req, mem_we, mem_ready, halted;
    logic [11:0] mem_addr, dbg_pc;
    logic [15:0] mem_wdata, mem_rdata, dbg_r0;

    logic [15:0] mem [4096];
    bit          wait_mode = 1'b0;
    int          wait_cnt = 0;
    int          cyc = 0;
    int          q_cyc[$];
    int          q_addr[$];
    int          q_we[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          stab_err = 0;
    logic        prev_pend = 1'b0;
    logic [11:0] prev_addr;
    logic        prev_we;

    always #5 clk = ~clk;

    acc_multicycle_core dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .halted(halted), .dbg_pc(dbg_pc), .dbg_r0(dbg_r0)
    );

    always_comb mem_rdata = mem[mem_addr];
    always_comb mem_ready = wait_mode ? (mem_req && wait_cnt == 2) : 1'b1;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!mem_req || mem_ready) wait_cnt <= 0;
        else                       wait_cnt <= wait_cnt + 1;
        if (mem_req && mem_ready) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            q_cyc.push_back(cyc);
            q_addr.push_back(int'(mem_addr));
            q_we.push_back(int'(mem_we));
        end
    end

    always @(negedge clk) begin
        if (!rst && mem_req && prev_pend && (mem_addr != prev_addr || mem_we != prev_we))
            stab_err <= stab_err + 1;
        prev_pend <= !rst && mem_req && !mem_ready;
        prev_addr <= mem_addr;
        prev_we   <= mem_we;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        q_cyc.delete(); q_addr.delete(); q_we.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_to_halt(input int budget, output int n);
        n = 0;
        while (!halted && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic load_basic();
        clear_mem();
        mem[0] = 16'h0100;      // LOAD 0x100
        mem[1] = 16'h4101;      // ADD 0x101
        mem[2] = 16'h1102;      // STORE 0x102
        mem[3] = 16'hE000;      // HALT
        mem[12'h100] = 16'h0005;
        mem[12'h101] = 16'hFFFE;
    endtask

    int  n;
    bit  saw_req;
    int  guard;

    initial begin
        rst = 1'b1;
        clear_mem();
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_halted", halted, 0);
        chk("rst_dbg_pc", dbg_pc, 0);
        chk("rst_dbg_r0", dbg_r0, 0);

        // Basic program, zero-wait memory.
        load_basic();
        wait_mode = 1'b0;
        do_reset();
        run_to_halt(200, n);
        chk("basic_halted", halted, 1);
        chk("basic_cycles", n - 1, 13);
        chk("basic_m102", mem[12'h102], 16'h0003);
        chk("basic_r0", dbg_r0, 16'h0003);
        saw_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            saw_req |= mem_req;
        end
        chk("halt_no_req", saw_req, 0);

        // Same program, ready on the third cycle of each request; seven requests add 14 cycles.
        load_basic();
        wait_mode = 1'b1;
        do_reset();
        stab_err = 0;
        run_to_halt(400, n);
        chk("wait_halted", halted, 1);
        chk("wait_cycles", n - 1, 27);
        chk("wait_m102", mem[12'h102], 16'h0003);
        chk("wait_stable", stab_err, 0);
        chk("wait_req_count", q_cyc.size(), 7);

        // BRZ taken (R0=0) then not taken (R0=1).
        clear_mem();
        wait_mode = 1'b0;
        mem[12'h000] = 16'h3050;   // BRZ 0x050
        mem[12'h050] = 16'h0100;   // LOAD 0x100
        mem[12'h051] = 16'h3060;   // BRZ 0x060
        mem[12'h052] = 16'hE000;   // HALT
        mem[12'h060] = 16'hE000;
        mem[12'h100] = 16'h0001;
        do_reset();
        run_to_halt(200, n);
        chk("brz_log_size", q_cyc.size(), 5);
        chk("brz_taken_addr", q_addr[1], 12'h050);
        chk("brz_taken_cyc", q_cyc[1] - q_cyc[0], 2);
        chk("load_latency", q_cyc[3] - q_cyc[1], 4);
        chk("brz_nt_addr", q_addr[4], 12'h052);
        chk("brz_nt_cyc", q_cyc[4] - q_cyc[3], 2);
        chk("brz_dbg_pc", dbg_pc, 12'h053);

        // Register ops and their boundary cases.
        clear_mem();
        mem[0]  = 16'hDFFF;        // ADDI -1
        mem[1]  = 16'h1200;        // STORE 0x200
        mem[2]  = 16'h8003;        // MVTO R3
        mem[3]  = 16'hC003;        // NOT R3
        mem[4]  = 16'h9003;        // MVFR R3
        mem[5]  = 16'h1201;        // STORE 0x201
        mem[6]  = 16'hD005;        // ADDI 5
        mem[7]  = 16'hC000;        // NOT R0
        mem[8]  = 16'h1202;        // STORE 0x202
        mem[9]  = 16'h8000;        // MVTO R0
        mem[10] = 16'h9000;        // MVFR R0
        mem[11] = 16'h1203;        // STORE 0x203
        mem[12] = 16'hB000;        // SUBR R0
        mem[13] = 16'h1204;        // STORE 0x204
        mem[14] = 16'hE000;
        mem[12'h201] = 16'h1234;
        mem[12'h204] = 16'h1234;
        do_reset();
        run_to_halt(300, n);
        chk("addi_m200", mem[12'h200], 16'hFFFF);
        chk("not_r3_m201", mem[12'h201], 16'h0000);
        chk("not_r0_m202", mem[12'h202], 16'hFFFA);
        chk("mv_r0_m203", mem[12'h203], 16'hFFFA);
        chk("subr_r0_m204", mem[12'h204], 16'h0000);
        chk("store_latency", q_cyc[3] - q_cyc[1], 3);
        chk("regop_latency", q_cyc[5] - q_cyc[4], 3);

        // JUMP to top of address space, NOP there wraps PC to 0.
        clear_mem();
        mem[12'h000] = 16'h2FFF;
        mem[12'hFFF] = 16'hF000;
        do_reset();
        for (int i = 0; i < 12; i++) @(negedge clk);
        chk("wrap_log_size", q_cyc.size() >= 3, 1);
        chk("wrap_jump_addr", q_addr[1], 12'hFFF);
        chk("wrap_next_addr", q_addr[2], 12'h000);
        chk("wrap_nop_cyc", q_cyc[2] - q_cyc[1], 2);
        chk("wrap_not_halted", halted, 0);

        // Async reset in the middle of a waited read.
        load_basic();
        wait_mode = 1'b1;
        do_reset();
        guard = 0;
        while (!(mem_req && !mem_we && mem_addr == 12'h100 && !mem_ready) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("abort_found_wait", guard < 50, 1);
        chk("abort_pre_pc", dbg_pc, 12'h001);
        rst = 1'b1;
        #1;
        chk("abort_req", mem_req, 0);
        chk("abort_pc", dbg_pc, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_init_req", mem_req, 0);
        @(negedge clk);
        chk("abort_fetch_req", mem_req, 1);
        chk("abort_fetch_addr", mem_addr, 12'h000);
        chk("abort_fetch_we", mem_we, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
